// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/operand/execute controller for the 4-bit accumulator CPU.
// It owns PC, IR, the operand byte and the C/Z flags. Every strobe is decoded
// from the registered state and IR, so an asynchronous reset clears them at once.
module cpu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [7:0]  rom_data,
    input  logic        alu_c,
    input  logic        alu_z,
    output logic [11:0] rom_addr,
    output logic [3:0]  imm,
    output logic [11:0] ram_addr,
    output logic [2:0]  alu_ctrl,
    output logic        acc_en,
    output logic        imm_oe,
    output logic        in_oe,
    output logic        acc_oe,
    output logic        ram_cs,
    output logic        ram_we,
    output logic        out_en,
    output logic        flag_c,
    output logic        flag_z,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        OPER  = 2'b01,
        EXEC  = 2'b10
    } state_t;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_PASS_B = 3'b010;
    localparam logic [2:0] ALU_ADD    = 3'b011;
    localparam logic [2:0] ALU_NAND   = 3'b100;

    state_t      cur_state, next_state;
    logic [11:0] pc;
    logic [7:0]  ir;
    logic [7:0]  op_lo;
    logic        flag_wr;
    logic        jump_taken;
    logic [3:0]  opcode;

    assign opcode   = ir[7:4];
    assign rom_addr = pc;
    assign imm      = ir[3:0];
    assign ram_addr = {ir[3:0], op_lo};
    assign state    = cur_state;

    // Opcodes 7, 8, 9 and B..F are followed by an operand byte.
    function automatic logic is_two_byte(input logic [3:0] op);
        return (op == 4'h7) || (op == 4'h8) || (op == 4'h9) || (op >= 4'hB);
    endfunction

    // State register; reset forces FETCH so all strobes fall immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur_state <= FETCH;
        else        cur_state <= next_state;
    end

    // Next-state and strobe decode from registered state and IR only.
    always_comb begin
        next_state = cur_state;
        alu_ctrl   = ALU_PASS_A;
        acc_en     = 1'b0;
        imm_oe     = 1'b0;
        in_oe      = 1'b0;
        acc_oe     = 1'b0;
        ram_cs     = 1'b0;
        ram_we     = 1'b0;
        out_en     = 1'b0;
        flag_wr    = 1'b0;
        jump_taken = 1'b0;
        case (cur_state)
            FETCH: begin
                if (run) next_state = is_two_byte(rom_data[7:4]) ? OPER : EXEC;
            end
            OPER: next_state = EXEC;
            EXEC: begin
                next_state = FETCH;
                case (opcode)
                    4'h1: begin imm_oe = 1'b1; alu_ctrl = ALU_PASS_B; acc_en = 1'b1; end
                    4'h2: begin in_oe  = 1'b1; alu_ctrl = ALU_PASS_B; acc_en = 1'b1; end
                    4'h3: begin imm_oe = 1'b1; alu_ctrl = ALU_SUB; flag_wr = 1'b1; end
                    4'h4: begin imm_oe = 1'b1; alu_ctrl = ALU_ADD;  acc_en = 1'b1; flag_wr = 1'b1; end
                    4'h5: begin imm_oe = 1'b1; alu_ctrl = ALU_SUB;  acc_en = 1'b1; flag_wr = 1'b1; end
                    4'h6: begin imm_oe = 1'b1; alu_ctrl = ALU_NAND; acc_en = 1'b1; flag_wr = 1'b1; end
                    4'h7: begin ram_cs = 1'b1; alu_ctrl = ALU_PASS_B; acc_en = 1'b1; end
                    4'h8: begin ram_cs = 1'b1; ram_we = 1'b1; acc_oe = 1'b1; end
                    4'h9: begin ram_cs = 1'b1; alu_ctrl = ALU_ADD; acc_en = 1'b1; flag_wr = 1'b1; end
                    4'hA: out_en = 1'b1;
                    4'hB: jump_taken = 1'b1;
                    4'hC: jump_taken = flag_c;
                    4'hD: jump_taken = ~flag_c;
                    4'hE: jump_taken = flag_z;
                    4'hF: jump_taken = ~flag_z;
                    default: ;
                endcase
            end
            default: next_state = FETCH;
        endcase
    end

    // PC, IR, operand byte and flags; PC wraps naturally at 12 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= 12'h000;
            ir     <= 8'h00;
            op_lo  <= 8'h00;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            case (cur_state)
                FETCH: begin
                    if (run) begin
                        ir <= rom_data;
                        pc <= pc + 12'd1;
                    end
                end
                OPER: begin
                    op_lo <= rom_data;
                    pc    <= pc + 12'd1;
                end
                EXEC: begin
                    if (flag_wr) begin
                        flag_c <= alu_c;
                        flag_z <= alu_z;
                    end
                    if (jump_taken) pc <= {ir[3:0], op_lo};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench: ROM, RAM, ALU and accumulator modelled around the sequencer.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b1;
    logic [7:0]  rom_data;
    logic        alu_c, alu_z;
    logic [11:0] rom_addr;
    logic [3:0]  imm;
    logic [11:0] ram_addr;
    logic [2:0]  alu_ctrl;
    logic        acc_en, imm_oe, in_oe, acc_oe, ram_cs, ram_we, out_en;
    logic        flag_c, flag_z;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    logic [7:0] rom [4096];
    logic [3:0] ram [4096];
    logic [3:0] acc = 4'h0;
    logic [3:0] in_port = 4'h5;
    logic [3:0] bus;
    logic [4:0] alu_res;

    cpu_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .rom_data(rom_data),
        .alu_c(alu_c), .alu_z(alu_z), .rom_addr(rom_addr), .imm(imm),
        .ram_addr(ram_addr), .alu_ctrl(alu_ctrl), .acc_en(acc_en),
        .imm_oe(imm_oe), .in_oe(in_oe), .acc_oe(acc_oe), .ram_cs(ram_cs),
        .ram_we(ram_we), .out_en(out_en), .flag_c(flag_c), .flag_z(flag_z),
        .state(state)
    );

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    // Data bus and ALU model.
    always_comb begin
        bus = 4'h0;
        if (imm_oe)              bus = imm;
        else if (in_oe)          bus = in_port;
        else if (acc_oe)         bus = acc;
        else if (ram_cs && !ram_we) bus = ram[ram_addr];
        case (alu_ctrl)
            3'b000:  alu_res = {1'b0, acc};
            3'b001:  alu_res = {1'b0, acc} - {1'b0, bus};
            3'b010:  alu_res = {1'b0, bus};
            3'b011:  alu_res = {1'b0, acc} + {1'b0, bus};
            3'b100:  alu_res = {1'b0, ~(acc & bus)};
            default: alu_res = 5'h00;
        endcase
    end
    assign alu_c = alu_res[4];
    assign alu_z = (alu_res[3:0] == 4'h0);

    // Accumulator and RAM write.
    always @(posedge clk) begin
        if (acc_en) acc <= alu_res[3:0];
        if (ram_cs && ram_we) ram[ram_addr] <= bus;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [6:0] strobes();
        return {acc_en, imm_oe, in_oe, acc_oe, ram_cs, ram_we, out_en};
    endfunction

    task automatic start();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    initial begin
        // Reset and first fetch
        clear_rom();
        rom[0] = 8'h1A; rom[1] = 8'h1A;
        #2;
        check("rst_state", 16'(state), 16'h0);
        check("rst_pc", 16'(rom_addr), 16'h000);
        check("rst_flags", 16'({flag_c, flag_z}), 16'h0);
        check("rst_strobes", 16'(strobes()), 16'h0);
        start();
        step(1);
        check("lit_state", 16'(state), 16'h2);
        check("lit_imm", 16'(imm), 16'hA);
        check("lit_acc_en", 16'(acc_en), 16'h1);
        check("lit_alu", 16'(alu_ctrl), 16'h2);
        step(1);
        check("lit_pc", 16'(rom_addr), 16'h001);
        check("lit_state2", 16'(state), 16'h0);
        check("lit_acc", 16'(acc), 16'hA);
        step(1);
        check("lit2_acc_en", 16'(acc_en), 16'h1);
        reset = 1'b0;
        #1;
        check("async_acc_en", 16'(acc_en), 16'h0);
        check("async_state", 16'(state), 16'h0);
        check("async_pc", 16'(rom_addr), 16'h000);

        // ADDI carry/zero, CMPI borrow
        clear_rom();
        rom[0] = 8'h1F; rom[1] = 8'h41; rom[2] = 8'h31;
        start();
        step(2);
        check("lf_acc", 16'(acc), 16'hF);
        step(2);
        check("addi_acc", 16'(acc), 16'h0);
        check("addi_flags", 16'({flag_c, flag_z}), 16'b10 + 16'b01);
        step(2);
        check("cmpi_flags", 16'({flag_c, flag_z}), 16'b10);
        check("cmpi_acc", 16'(acc), 16'h0);

        // STM / LDM
        clear_rom();
        rom[0] = 8'h17; rom[1] = 8'h85; rom[2] = 8'hA3;
        rom[3] = 8'h12; rom[4] = 8'h75; rom[5] = 8'hA3;
        start();
        step(3);
        check("stm_oper", 16'(state), 16'h1);
        step(1);
        check("stm_state", 16'(state), 16'h2);
        check("stm_strobes", 16'(strobes()), 16'b0001110);
        check("stm_addr", 16'(ram_addr), 16'h5A3);
        step(1);
        check("stm_done", 16'(state), 16'h0);
        check("stm_pc", 16'(rom_addr), 16'h003);
        check("stm_ram", 16'(ram[12'h5A3]), 16'h7);
        step(2);
        check("lit2_acc", 16'(acc), 16'h2);
        step(2);
        check("ldm_strobes", 16'(strobes()), 16'b1000100);
        check("ldm_alu", 16'(alu_ctrl), 16'h2);
        step(1);
        check("ldm_acc", 16'(acc), 16'h7);
        check("ldm_pc", 16'(rom_addr), 16'h006);

        // Jumps with Z=1, C=0
        clear_rom();
        rom[0] = 8'h10; rom[1] = 8'h30;
        rom[2] = 8'hE4; rom[3] = 8'h20;
        rom[12'h420] = 8'hF4; rom[12'h421] = 8'h20;
        rom[12'h422] = 8'hBF; rom[12'h423] = 8'hFE;
        rom[12'hFFE] = 8'hB0; rom[12'hFFF] = 8'h00;
        start();
        step(4);
        check("cmp0_flags", 16'({flag_c, flag_z}), 16'b01);
        step(3);
        check("jz_taken", 16'(rom_addr), 16'h420);
        step(3);
        check("jnz_not", 16'(rom_addr), 16'h422);
        step(3);
        check("jmp_ffe", 16'(rom_addr), 16'hFFE);
        step(3);
        check("jmp_000", 16'(rom_addr), 16'h000);

        // PC wrap: 2-byte instruction at 0xFFF
        clear_rom();
        rom[0] = 8'h23; rom[1] = 8'hBF; rom[2] = 8'hFF; rom[12'hFFF] = 8'hB1;
        start();
        step(2);
        check("in_acc", 16'(acc), 16'h5);
        step(3);
        check("wrap_pc", 16'(rom_addr), 16'hFFF);
        step(1);
        check("wrap_oper", 16'({state, rom_addr}), {2'b0, 2'b01, 12'h000});
        step(2);
        check("wrap_jmp", 16'(rom_addr), 16'h123);

        // run dropped during OPER
        clear_rom();
        rom[0] = 8'h85; rom[1] = 8'hA3; rom[2] = 8'hA0;
        start();
        step(1);
        run = 1'b0;
        step(1);
        check("hold_exec", 16'(ram_cs), 16'h1);
        step(1);
        check("hold_pc", 16'(rom_addr), 16'h002);
        step(2);
        check("hold_state", 16'(state), 16'h0);
        check("hold_pc2", 16'(rom_addr), 16'h002);
        check("hold_strobes", 16'(strobes()), 16'h0);
        run = 1'b1;
        step(1);
        check("resume_out", 16'(out_en), 16'h1);
        check("resume_pc", 16'(rom_addr), 16'h003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle fetch/execute controller for the 4-bit accumulator processor. It owns the 12-bit program counter, instruction register and C/Z flags. It sequences program-ROM fetches and drives every strobe of the datapath: ALU control, accumulator load, data-bus output enables, RAM chip-select/write-enable and output-port load. The block sits between the 8-bit program ROM and the 4-bit datapath (ALU, accumulator, RAM, I/O ports).

## Interface
- No parameters; widths are fixed at 12-bit address, 8-bit instruction byte and 4-bit data.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  1 = execute; 0 = hold at the next instruction boundary.
- rom_data  in  8  program byte at rom_addr; combinational ROM.
- alu_c  in  1  ALU carry/borrow, bit 4 of the result.
- alu_z  in  1  ALU zero.
- rom_addr  out  12  program counter.
- imm  out  4  IR[3:0], the instruction operand.
- ram_addr  out  12  {IR[3:0], op_lo}.
- alu_ctrl  out  3  ALU operation: 000 pass A, 001 A-B, 010 pass B, 011 A+B, 100 NAND.
- acc_en  out  1  accumulator load.
- imm_oe, in_oe, acc_oe  out  1 each  data-bus drivers. At most one is high in any cycle; RAM drives the bus on ram_cs&~ram_we.
- ram_cs, ram_we  out  1 each  RAM strobes.
- out_en  out  1  output-port load from the accumulator.
- flag_c, flag_z  out  1 each  registered flags.
- state  out  2  00 FETCH, 01 OPER, 10 EXEC.

## Operation
Instruction format:
- Byte 0: opcode IR[7:4], operand IR[3:0].
- Opcodes 7, 8, 9 and B through F carry a second byte op_lo. These are the 2-byte instructions.

Opcode map (ALU B input = data bus):
- 0 NOP: no action.
- 1 LIT: imm_oe, alu 010, acc_en.
- 2 IN: in_oe, alu 010, acc_en.
- 3 CMPI: imm_oe, alu 001, flags only.
- 4 ADDI: imm_oe, alu 011, acc_en, flags.
- 5 SUBI: imm_oe, alu 001, acc_en, flags.
- 6 NANDI: imm_oe, alu 100, acc_en, flags.
- 7 LDM: ram_cs, alu 010, acc_en.
- 8 STM: ram_cs, ram_we, acc_oe.
- 9 ADDM: ram_cs, alu 011, acc_en, flags.
- A OUT: out_en.
- B JMP, C JC, D JNC, E JZ, F JNZ: conditional on flag_c / flag_z. When taken, PC <= {IR[3:0], op_lo}.

State machine:
- FETCH:
  - If run=1: IR <= rom_data, PC <= PC+1. Go to OPER for 2-byte opcodes, else go to EXEC.
  - If run=0: PC and IR hold; all strobes stay 0.
- OPER: op_lo <= rom_data, PC <= PC+1, go to EXEC.
- EXEC: assert the strobes for the opcode, go to FETCH.
  - Flag-writing opcodes load flag_c <= alu_c and flag_z <= alu_z at the EXEC clock edge.
  - Taken jumps overwrite PC at that edge.

Rules:
- Strobes are decoded only from the registered state and IR. All strobes are 0 outside EXEC.
- PC arithmetic is modulo 4096: 0xFFF+1 = 0x000. A 2-byte instruction at 0xFFF takes op_lo from 0x000.
- Opcodes 3–6 and 9 update flags. All other opcodes leave flags unchanged.
- run is sampled only in FETCH. Deasserting run mid-instruction completes that instruction.

Reset (reset=0, asynchronous):
- State FETCH.
- PC, IR, op_lo = 0.
- flag_c, flag_z = 0.
- All strobes drop to 0 immediately without waiting for clk. An interrupted STM therefore never completes its write.
- The first fetch happens at the first rising edge after reset returns high with run=1.

## Timing
- 1-byte instruction: 2 cycles (FETCH, EXEC).
- 2-byte instruction: 3 cycles (FETCH, OPER, EXEC).
- rom_addr changes only at clock edges. rom_data must be valid by the end of FETCH and OPER.
- EXEC strobes are valid for that whole cycle. RAM write and accumulator load complete within it.
- Taken jump: the next FETCH reads the target address. There are no delay slots.
- Not-taken jump: execution continues at PC+2 from the jump's address.

## Test plan
- Reset with rom at 0x000 = 0x1A, run=1 → at edge 1 state=EXEC, imm=A, acc_en=1, alu_ctrl=010; at edge 2 rom_addr=0x001 and state=FETCH. Assert reset low during EXEC → acc_en falls before the next clk edge.
- Program `1F` then `41`, with ALU model and accumulator → after ADDI, acc=0, flag_c=1, flag_z=1. Then `3x` with acc=0, imm=1 → flag_c=1 (borrow), flag_z=0, acc unchanged.
- Program `85 A3` with acc=7 → in EXEC, ram_cs=1, ram_we=1, acc_oe=1, ram_addr=0x5A3; 3 cycles total. Then `75 A3` → ram_cs=1, ram_we=0, acc_en=1.
- Jumps with flag_z=1: `E4 20` → next rom_addr=0x420. `F4 20` → next rom_addr = jump address + 2. `B0 00` at 0xFFE → rom_addr=0x000.
- Wrap-around: PC=0xFFF holding `B1`, ROM[0x000]=0x23 → op_lo from 0x000, PC jumps to 0x123.
- Drop run during OPER → the instruction finishes, then PC holds in FETCH with all strobes 0. Raise run → fetch resumes at the held PC.
